axil_lite_arbiter_2to1: RTL and testbench
=========================================

# axil_lite_arbiter_2to1

Round-robin arbiter that shares one AXI4-Lite slave port (a register-file IP such as the time-tag USR_ACCESS block) between two AXI4-Lite requesters, e.g. the PS general-purpose port and an on-fabric sequencer. It serialises transactions so exactly one read or one write is in flight at the slave, and it routes the response back to the originating requester unchanged. It sits between the interconnect and the peripheral in the block design.

## Interface
- ADDR_WIDTH, 32, address width (AW) on all ports
- DATA_WIDTH, 32, data width (DW); strobe width DW/8

Ports. Requester-side vectors are packed; slice i belongs to requester i.
- ACLK  in  1  clock, all logic rising-edge
- ARESETN  in  1  reset, asynchronous assert, active-low
- s_awaddr, s_awprot, s_awvalid in / s_awready out  2×{AW,3,1}/2  requester write-address channels
- s_wdata, s_wstrb, s_wvalid in / s_wready out  2×{DW,DW/8,1}/2  requester write-data channels
- s_bresp, s_bvalid out / s_bready in  2×{2,1}/2  requester write-response channels
- s_araddr, s_arprot, s_arvalid in / s_arready out  2×{AW,3,1}/2  requester read-address channels
- s_rdata, s_rresp, s_rvalid out / s_rready in  2×{DW,2,1}/2  requester read-data channels
- m_awaddr, m_awprot, m_awvalid out / m_awready in  AW,3,1/1  slave write-address channel
- m_wdata, m_wstrb, m_wvalid out / m_wready in  DW,DW/8,1/1  slave write-data channel
- m_bresp, m_bvalid in / m_bready out  2,1/1  slave write-response channel
- m_araddr, m_arprot, m_arvalid out / m_arready in  AW,3,1/1  slave read-address channel
- m_rdata, m_rresp, m_rvalid in / m_rready out  DW,2,1/1  slave read-data channel

## Operation
- States: IDLE, WR (AW/W phase), WB (B phase), RD (AR phase), RR (R phase). Registers: state, grant g (1 bit), rr_ptr (1 bit), aw_done, w_done.
- IDLE: req_i = s_awvalid[i] | s_arvalid[i]. With both requesters active, grant rr_ptr; otherwise grant the only active one. Within the granted requester, write wins over read. Go to WR or RD, latch g.
- WR: m_awvalid = s_awvalid[g] & !aw_done; m_wvalid = s_wvalid[g] & !w_done; payloads muxed from slice g; s_awready[g]/s_wready[g] mirror m_awready/m_wready while not done. Set aw_done/w_done on respective handshakes (either order, or same cycle). When both are done, go to WB.
- WB: s_bvalid[g] = m_bvalid, s_bresp[g] = m_bresp, m_bready = s_bready[g]. On handshake go to IDLE, set rr_ptr = ~g, clear done flags.
- RD: AR forwarded as in WR. On handshake go to RR.
- RR: R forwarded to slice g. On handshake go to IDLE, set rr_ptr = ~g.
- Non-granted slices and all channels outside the current phase: readies and valids held 0. Responses (SLVERR/DECERR) are passed through unmodified.
- Fairness: after each transaction priority rotates, so a waiting requester waits at most one transaction.
- Requester dropping valid before handshake is an AXI violation; no check, no recovery.

## Timing
- Reset (async): state IDLE, rr_ptr 0, g 0, done flags 0; all valid/ready outputs 0 immediately, payload outputs 0.
- Reset mid-transaction aborts it; no response is ever delivered for it.
- Arbitration costs 1 cycle: a request sampled in IDLE at edge N gives m_awvalid/m_arvalid in cycle N+1.
- Channel forwarding is combinational in the granted phase (zero added latency). The return to IDLE costs 1 cycle, so there is 1 idle cycle minimum between back-to-back transactions.
- Minimum write: request cycle 0, AW+W accepted cycle 1, B in cycle 2 or later. Minimum read: AR cycle 1, R cycle 2 or later.

## Structure
- Package axil_arb_pkg: state enum, RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
- Sub-module axil_arb_rr_grant: combinational request→grant plus write-over-read select, with rr_ptr as input.

## Test plan
- Req0 writes 0x0101FFFF to 0x0, slave OKAY → m_awvalid one cycle after request, s_bresp[0]=00, all slice-1 readies stay 0.
- Both requesters write in the same cycle after reset (req0 0xabcd0001@0x4, req1 0xdead0011@0x8) → req0 completes first, then req1; rr_ptr ends at 0.
- Req0 has write+read pending and req1 has a read pending → order req0 write, req1 read, req0 read.
- Slave holds m_awready low 3 cycles with m_wready immediate → s_wready[0] pulses once, m_bready stays 0 until AW is accepted, then B completes.
- Slave returns rresp=SLVERR, rdata 0xbeef0011 to req1 → s_rresp[1]=10, s_rdata[1]=0xbeef0011, slice 0 rvalid stays 0.
- ARESETN asserted in RR with m_rvalid high → all valid/ready outputs 0 in the same cycle; after release, state IDLE, rr_ptr 0, next request granted normally.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared definitions for the two-requester AXI4-Lite arbiter.
//   arb_state_e : transaction phase of the arbiter FSM
//   RESP_*      : AXI4-Lite response encodings (passed through unmodified)
package axil_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,   // waiting for a request, arbitration happens here
      ST_WR   = 3'd1,   // AW and W forwarding
      ST_WB   = 3'd2,   // B forwarding
      ST_RD   = 3'd3,   // AR forwarding
      ST_RR   = 3'd4    // R forwarding
   } arb_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_arb_rr_grant.sv
// Combinational round-robin grant for two requesters.
//   wr_req  : per-requester write request (AWVALID)
//   rd_req  : per-requester read request (ARVALID)
//   rr_ptr  : requester that wins when both are active
//   gnt_vld : at least one requester is active
//   gnt_idx : granted requester
//   gnt_wr  : granted requester issues a write (write wins over read)
module axil_arb_rr_grant (
   input  logic [1:0] wr_req,
   input  logic [1:0] rd_req,
   input  logic       rr_ptr,
   output logic       gnt_vld,
   output logic       gnt_idx,
   output logic       gnt_wr
);

   logic [1:0] req;

   assign req = wr_req | rd_req;

   always_comb begin
      gnt_vld = |req;
      // With a single active requester req[1] directly names it; with none
      // the index is irrelevant because gnt_vld is low.
      if (req == 2'b11) gnt_idx = rr_ptr;
      else              gnt_idx = req[1];
      gnt_wr = wr_req[gnt_idx];
   end

endmodule

// File: rtl/axil_lite_arbiter_2to1.sv
// Round-robin arbiter sharing one AXI4-Lite slave between two requesters.
// Exactly one read or write is in flight at the slave; the response goes
// back to the originating requester unchanged.
//   ACLK, ARESETN       : clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*     : requester write channels, slice i = requester i
//   s_ar*/s_r*          : requester read channels, slice i = requester i
//   m_aw*/m_w*/m_b*     : slave write channels
//   m_ar*/m_r*          : slave read channels
module axil_lite_arbiter_2to1
   import axil_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   // requester write address
   input  logic [1:0][ADDR_WIDTH-1:0]        s_awaddr,
   input  logic [1:0][2:0]                   s_awprot,
   input  logic [1:0]                        s_awvalid,
   output logic [1:0]                        s_awready,
   // requester write data
   input  logic [1:0][DATA_WIDTH-1:0]        s_wdata,
   input  logic [1:0][DATA_WIDTH/8-1:0]      s_wstrb,
   input  logic [1:0]                        s_wvalid,
   output logic [1:0]                        s_wready,
   // requester write response
   output logic [1:0][1:0]                   s_bresp,
   output logic [1:0]                        s_bvalid,
   input  logic [1:0]                        s_bready,
   // requester read address
   input  logic [1:0][ADDR_WIDTH-1:0]        s_araddr,
   input  logic [1:0][2:0]                   s_arprot,
   input  logic [1:0]                        s_arvalid,
   output logic [1:0]                        s_arready,
   // requester read data
   output logic [1:0][DATA_WIDTH-1:0]        s_rdata,
   output logic [1:0][1:0]                   s_rresp,
   output logic [1:0]                        s_rvalid,
   input  logic [1:0]                        s_rready,
   // slave write address
   output logic [ADDR_WIDTH-1:0]             m_awaddr,
   output logic [2:0]                        m_awprot,
   output logic                              m_awvalid,
   input  logic                              m_awready,
   // slave write data
   output logic [DATA_WIDTH-1:0]             m_wdata,
   output logic [DATA_WIDTH/8-1:0]           m_wstrb,
   output logic                              m_wvalid,
   input  logic                              m_wready,
   // slave write response
   input  logic [1:0]                        m_bresp,
   input  logic                              m_bvalid,
   output logic                              m_bready,
   // slave read address
   output logic [ADDR_WIDTH-1:0]             m_araddr,
   output logic [2:0]                        m_arprot,
   output logic                              m_arvalid,
   input  logic                              m_arready,
   // slave read data
   input  logic [DATA_WIDTH-1:0]             m_rdata,
   input  logic [1:0]                        m_rresp,
   input  logic                              m_rvalid,
   output logic                              m_rready
);

   arb_state_e state;
   logic       g;
   logic       rr_ptr;
   logic       aw_done;
   logic       w_done;

   logic       gnt_vld;
   logic       gnt_idx;
   logic       gnt_wr;

   logic       aw_hs;
   logic       w_hs;

   axil_arb_rr_grant u_grant (
      .wr_req  (s_awvalid),
      .rd_req  (s_arvalid),
      .rr_ptr  (rr_ptr),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
      .gnt_wr  (gnt_wr)
   );

   assign aw_hs = m_awvalid & m_awready;
   assign w_hs  = m_wvalid & m_wready;

   // Forwarding is purely combinational from the current phase, so every
   // output collapses to zero the moment reset forces the state to IDLE.
   always_comb begin
      m_awaddr  = '0;
      m_awprot  = '0;
      m_awvalid = 1'b0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      m_araddr  = '0;
      m_arprot  = '0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      s_awready = '0;
      s_wready  = '0;
      s_bvalid  = '0;
      s_bresp   = '0;
      s_arready = '0;
      s_rvalid  = '0;
      s_rdata   = '0;
      s_rresp   = '0;
      case (state)
         ST_WR: begin
            m_awaddr     = s_awaddr[g];
            m_awprot     = s_awprot[g];
            m_awvalid    = s_awvalid[g] & ~aw_done;
            m_wdata      = s_wdata[g];
            m_wstrb      = s_wstrb[g];
            m_wvalid     = s_wvalid[g] & ~w_done;
            s_awready[g] = m_awready & ~aw_done;
            s_wready[g]  = m_wready & ~w_done;
         end
         ST_WB: begin
            s_bvalid[g] = m_bvalid;
            s_bresp[g]  = m_bresp;
            m_bready    = s_bready[g];
         end
         ST_RD: begin
            m_araddr     = s_araddr[g];
            m_arprot     = s_arprot[g];
            m_arvalid    = s_arvalid[g];
            s_arready[g] = m_arready;
         end
         ST_RR: begin
            s_rvalid[g] = m_rvalid;
            s_rdata[g]  = m_rdata;
            s_rresp[g]  = m_rresp;
            m_rready    = s_rready[g];
         end
         default: ;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state   <= ST_IDLE;
         g       <= 1'b0;
         rr_ptr  <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt_vld) begin
                  g     <= gnt_idx;
                  state <= gnt_wr ? ST_WR : ST_RD;
               end
            end
            ST_WR: begin
               // AW and W may complete in either order or together.
               aw_done <= aw_done | aw_hs;
               w_done  <= w_done | w_hs;
               if ((aw_done | aw_hs) && (w_done | w_hs)) state <= ST_WB;
            end
            ST_WB: begin
               if (m_bvalid && m_bready) begin
                  state   <= ST_IDLE;
                  rr_ptr  <= ~g;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            ST_RD: begin
               if (m_arvalid && m_arready) state <= ST_RR;
            end
            ST_RR: begin
               if (m_rvalid && m_rready) begin
                  state  <= ST_IDLE;
                  rr_ptr <= ~g;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_lite_arbiter_2to1.sv
// Directed bench for axil_lite_arbiter_2to1: drives both requesters and the
// slave side by hand and checks each phase against hand-computed values.
module tb_axil_lite_arbiter_2to1;

   localparam int AW = 32;
   localparam int DW = 32;

   logic                      tb_ACLK = 1'b0;
   logic                      ARESETN;
   logic [1:0][AW-1:0]        s_awaddr;
   logic [1:0][2:0]           s_awprot;
   logic [1:0]                s_awvalid;
   logic [1:0]                s_awready;
   logic [1:0][DW-1:0]        s_wdata;
   logic [1:0][DW/8-1:0]      s_wstrb;
   logic [1:0]                s_wvalid;
   logic [1:0]                s_wready;
   logic [1:0][1:0]           s_bresp;
   logic [1:0]                s_bvalid;
   logic [1:0]                s_bready;
   logic [1:0][AW-1:0]        s_araddr;
   logic [1:0][2:0]           s_arprot;
   logic [1:0]                s_arvalid;
   logic [1:0]                s_arready;
   logic [1:0][DW-1:0]        s_rdata;
   logic [1:0][1:0]           s_rresp;
   logic [1:0]                s_rvalid;
   logic [1:0]                s_rready;
   logic [AW-1:0]             m_awaddr;
   logic [2:0]                m_awprot;
   logic                      m_awvalid;
   logic                      m_awready;
   logic [DW-1:0]             m_wdata;
   logic [DW/8-1:0]           m_wstrb;
   logic                      m_wvalid;
   logic                      m_wready;
   logic [1:0]                m_bresp;
   logic                      m_bvalid;
   logic                      m_bready;
   logic [AW-1:0]             m_araddr;
   logic [2:0]                m_arprot;
   logic                      m_arvalid;
   logic                      m_arready;
   logic [DW-1:0]             m_rdata;
   logic [1:0]                m_rresp;
   logic                      m_rvalid;
   logic                      m_rready;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 tb_ACLK = ~tb_ACLK;

   axil_lite_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .ACLK      (tb_ACLK),
      .ARESETN   (ARESETN),
      .s_awaddr  (s_awaddr),
      .s_awprot  (s_awprot),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),
      .s_bresp   (s_bresp),
      .s_bvalid  (s_bvalid),
      .s_bready  (s_bready),
      .s_araddr  (s_araddr),
      .s_arprot  (s_arprot),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready),
      .m_awaddr  (m_awaddr),
      .m_awprot  (m_awprot),
      .m_awvalid (m_awvalid),
      .m_awready (m_awready),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .m_wvalid  (m_wvalid),
      .m_wready  (m_wready),
      .m_bresp   (m_bresp),
      .m_bvalid  (m_bvalid),
      .m_bready  (m_bready),
      .m_araddr  (m_araddr),
      .m_arprot  (m_arprot),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_rdata   (m_rdata),
      .m_rresp   (m_rresp),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge, outputs are checked 1 unit later.
   task automatic tick();
      @(posedge tb_ACLK);
      #2;
   endtask

   // Runs a granted write for requester idx, starting from the IDLE cycle in
   // which its request is already visible.
   task automatic do_write(input string tag, input int idx, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] resp);
      logic [1:0] sel;
      sel = 2'(1 << idx);
      tick(); #1;
      chk({tag, "_awvalid"}, 64'(m_awvalid), 64'(1));
      chk({tag, "_awaddr"},  64'(m_awaddr),  64'(addr));
      chk({tag, "_wdata"},   64'(m_wdata),   64'(data));
      m_awready = 1'b1;
      m_wready  = 1'b1;
      #1;
      chk({tag, "_s_awready"}, 64'(s_awready), 64'(sel));
      chk({tag, "_s_wready"},  64'(s_wready),  64'(sel));
      tick();
      s_awvalid[idx] = 1'b0;
      s_wvalid[idx]  = 1'b0;
      m_awready = 1'b0;
      m_wready  = 1'b0;
      m_bvalid  = 1'b1;
      m_bresp   = resp;
      s_bready[idx] = 1'b1;
      #1;
      chk({tag, "_s_bvalid"}, 64'(s_bvalid),     64'(sel));
      chk({tag, "_s_bresp"},  64'(s_bresp[idx]), 64'(resp));
      chk({tag, "_m_bready"}, 64'(m_bready),     64'(1));
      tick();
      m_bvalid = 1'b0;
      m_bresp  = 2'b00;
      s_bready[idx] = 1'b0;
      #1;
      chk({tag, "_b_closed"}, 64'(s_bvalid), 64'(0));
   endtask

   task automatic do_read(input string tag, input int idx, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] resp);
      logic [1:0] sel;
      sel = 2'(1 << idx);
      tick(); #1;
      chk({tag, "_arvalid"}, 64'(m_arvalid), 64'(1));
      chk({tag, "_araddr"},  64'(m_araddr),  64'(addr));
      chk({tag, "_awvalid0"}, 64'(m_awvalid), 64'(0));
      m_arready = 1'b1;
      #1;
      chk({tag, "_s_arready"}, 64'(s_arready), 64'(sel));
      tick();
      s_arvalid[idx] = 1'b0;
      m_arready = 1'b0;
      m_rvalid  = 1'b1;
      m_rdata   = data;
      m_rresp   = resp;
      s_rready[idx] = 1'b1;
      #1;
      chk({tag, "_s_rvalid"}, 64'(s_rvalid),     64'(sel));
      chk({tag, "_s_rdata"},  64'(s_rdata[idx]), 64'(data));
      chk({tag, "_s_rresp"},  64'(s_rresp[idx]), 64'(resp));
      chk({tag, "_m_rready"}, 64'(m_rready),     64'(1));
      tick();
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_rresp  = 2'b00;
      s_rready[idx] = 1'b0;
      #1;
      chk({tag, "_r_closed"}, 64'(s_rvalid), 64'(0));
   endtask

   initial begin
      ARESETN   = 1'b0;
      s_awaddr  = '0; s_awprot = '0; s_awvalid = '0;
      s_wdata   = '0; s_wstrb  = '0; s_wvalid  = '0;
      s_bready  = '0;
      s_araddr  = '0; s_arprot = '0; s_arvalid = '0;
      s_rready  = '0;
      m_awready = 1'b0; m_wready = 1'b0;
      m_bresp   = 2'b00; m_bvalid = 1'b0;
      m_arready = 1'b0;
      m_rdata   = '0; m_rresp = 2'b00; m_rvalid = 1'b0;

      // reset state: requests are not forwarded while reset is held
      tick();
      s_awvalid = 2'b11;
      s_arvalid = 2'b11;
      m_awready = 1'b1;
      tick(); #1;
      chk("rst_m_awvalid", 64'(m_awvalid), 64'(0));
      chk("rst_m_arvalid", 64'(m_arvalid), 64'(0));
      chk("rst_s_awready", 64'(s_awready), 64'(0));
      chk("rst_m_awaddr",  64'(m_awaddr),  64'(0));
      chk("rst_state",     64'(dut.state), 64'(0));
      chk("rst_rr_ptr",    64'(dut.rr_ptr), 64'(0));
      s_awvalid = '0;
      s_arvalid = '0;
      m_awready = 1'b0;
      tick();
      ARESETN = 1'b1;

      // single write from requester 0
      tick();
      s_awaddr[0]  = 32'h0;
      s_awvalid[0] = 1'b1;
      s_wdata[0]   = 32'h0101FFFF;
      s_wstrb[0]   = 4'hF;
      s_wvalid[0]  = 1'b1;
      #1;
      chk("t1_req_cycle_awvalid", 64'(m_awvalid), 64'(0));
      do_write("t1", 0, 32'h0, 32'h0101FFFF, 2'b00);

      // simultaneous writes after reset: requester 0 first, then 1
      ARESETN = 1'b0;
      tick();
      ARESETN = 1'b1;
      s_awaddr[0] = 32'h4;  s_wdata[0] = 32'habcd0001; s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
      s_awaddr[1] = 32'h8;  s_wdata[1] = 32'hdead0011; s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1;
      s_wstrb = {4'hF, 4'hF};
      do_write("t2a", 0, 32'h4, 32'habcd0001, 2'b00);
      chk("t2_rr_mid", 64'(dut.rr_ptr), 64'(1));
      do_write("t2b", 1, 32'h8, 32'hdead0011, 2'b00);
      chk("t2_rr_end", 64'(dut.rr_ptr), 64'(0));

      // req0 write+read, req1 read: req0 write, req1 read (SLVERR), req0 read
      s_awaddr[0] = 32'h10; s_wdata[0] = 32'h11111111; s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
      s_araddr[0] = 32'h20; s_arvalid[0] = 1'b1;
      s_araddr[1] = 32'h30; s_arvalid[1] = 1'b1;
      do_write("t3w0", 0, 32'h10, 32'h11111111, 2'b00);
      do_read("t3r1", 1, 32'h30, 32'hbeef0011, 2'b10);
      do_read("t3r0", 0, 32'h20, 32'h12345678, 2'b00);

      // slave stalls AW for 3 cycles, W accepted immediately
      s_awaddr[0] = 32'h44; s_wdata[0] = 32'h5a5a5a5a; s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
      tick();
      m_wready = 1'b1;
      #1;
      chk("t4_wready_pulse", 64'(s_wready),  64'(1));
      chk("t4_awready_low",  64'(s_awready), 64'(0));
      tick();
      s_wvalid[0] = 1'b0;
      #1;
      chk("t4_wready_done",  64'(s_wready),  64'(0));
      chk("t4_wvalid_done",  64'(m_wvalid),  64'(0));
      chk("t4_bready_c1",    64'(m_bready),  64'(0));
      chk("t4_awvalid_held", 64'(m_awvalid), 64'(1));
      tick(); #1;
      chk("t4_bready_c2",    64'(m_bready),  64'(0));
      chk("t4_wready_c2",    64'(s_wready),  64'(0));
      m_awready = 1'b1;
      #1;
      chk("t4_awready", 64'(s_awready), 64'(1));
      tick();
      s_awvalid[0] = 1'b0;
      m_awready = 1'b0;
      m_wready  = 1'b0;
      m_bvalid  = 1'b1;
      m_bresp   = 2'b11;
      s_bready[0] = 1'b1;
      #1;
      chk("t4_bvalid",  64'(s_bvalid),   64'(1));
      chk("t4_bresp",   64'(s_bresp[0]), 64'(2'b11));
      chk("t4_m_bready", 64'(m_bready),  64'(1));
      tick();
      m_bvalid = 1'b0;
      m_bresp  = 2'b00;
      s_bready[0] = 1'b0;

      // reset asserted while in RR with m_rvalid high
      s_araddr[1] = 32'h40; s_arvalid[1] = 1'b1;
      tick(); #1;
      chk("t6_arvalid", 64'(m_arvalid), 64'(1));
      m_arready = 1'b1;
      tick();
      s_arvalid[1] = 1'b0;
      m_arready = 1'b0;
      m_rvalid  = 1'b1;
      m_rdata   = 32'hcafe0001;
      s_rready  = 2'b10;
      #1;
      chk("t6_rvalid_pre", 64'(s_rvalid), 64'(2'b10));
      ARESETN = 1'b0;
      #1;
      chk("t6_rst_rvalid", 64'(s_rvalid), 64'(0));
      chk("t6_rst_rready", 64'(m_rready), 64'(0));
      chk("t6_rst_rdata",  64'(s_rdata),  64'(0));
      chk("t6_rst_state",  64'(dut.state), 64'(0));
      m_rvalid = 1'b0;
      m_rdata  = '0;
      s_rready = '0;
      tick();
      ARESETN = 1'b1;
      #1;
      chk("t6_post_rr_ptr", 64'(dut.rr_ptr), 64'(0));
      chk("t6_post_rvalid", 64'(s_rvalid),   64'(0));
      s_awaddr[0] = 32'h0C; s_wdata[0] = 32'h77770000; s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
      #1;
      chk("t6_req_cycle", 64'(m_awvalid), 64'(0));
      do_write("t6w", 0, 32'h0C, 32'h77770000, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
